// File: rtl/serial_adder_n_if.sv
// serial_adder_n_if
//   Bundles the operand/result handshake of the bit-serial adder so the
//   requester and the adder connect through a single port.
//
//   Signals (WIDTH = operand/result width):
//     start        request a new operation (requester -> adder)
//     sub          0 = a+b+cin, 1 = a-b (requester -> adder)
//     cin          carry-in for add mode (requester -> adder)
//     a, b         operands (requester -> adder)
//     sum          registered result (adder -> requester)
//     cout         carry-out / not-borrow flag (adder -> requester)
//     ovf          signed overflow of the result (adder -> requester)
//     busy         operation in progress (adder -> requester)
//     done         one-cycle pulse when sum/cout/ovf are fresh (adder -> requester)
//
//   Modports: master = requester side, slave = adder side.
interface serial_adder_n_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, sub, cin, a, b,
    input  sum, cout, ovf, busy, done
  );

  modport slave (
    input  start, sub, cin, a, b,
    output sum, cout, ovf, busy, done
  );

endinterface

// File: rtl/serial_adder_n.sv
// serial_adder_n
//   Bit-serial, LSB-first adder/subtractor built around one registered
//   full-adder cell. One operand bit is processed per clock, so a result
//   takes WIDTH cycles after the request is accepted, followed by a
//   one-cycle DONE state in which a new request may already be accepted.
//
//   Parameters:
//     WIDTH  operand/result width in bits (1..64)
//
//   Ports:
//     clk    rising-edge clock
//     rst    synchronous active-high reset, has priority over everything
//     bus    serial_adder_n_if.slave: start/sub/cin/a/b in,
//            sum/cout/ovf/busy/done out
module serial_adder_n #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  serial_adder_n_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] ar;
  logic [WIDTH-1:0] br;
  logic [WIDTH-1:0] rr;
  logic [WIDTH-1:0] rr_next;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             s;
  logic             c_next;
  logic             cmsb;
  logic             last_bit;
  logic             accept;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  // State register. Reset always returns to IDLE, which also drops any
  // operation in flight without producing a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the single full-adder cell. A request is only
  // taken in IDLE or DONE, so start is simply ignored while running. The
  // result bit is shifted into the top of rr; after WIDTH shifts the first
  // bit processed (the LSB) has arrived at bit 0. The carry into the MSB
  // is the carry used on the last bit, and comparing it to the carry out
  // of the MSB gives the two's-complement overflow.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    s          = ar[0] ^ br[0] ^ c;
    c_next     = (ar[0] & br[0]) | (c & (ar[0] ^ br[0]));
    cmsb       = c;
    rr_next    = rr >> 1;
    rr_next[WIDTH-1] = s;
    last_bit   = (state == RUN) && (cnt == CW'(WIDTH - 1));

    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers. Subtraction is a + ~b + 1, so b is inverted on
  // capture and the initial carry forced to 1; in that mode cin is unused
  // and cout becomes the not-borrow flag. The visible result registers
  // are only written on the last bit, so they stay stable while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      ar     <= '0;
      br     <= '0;
      rr     <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      ar  <= bus.a;
      br  <= bus.sub ? ~bus.b : bus.b;
      c   <= bus.sub ? 1'b1 : bus.cin;
      rr  <= '0;
      cnt <= '0;
    end else if (state == RUN) begin
      ar  <= ar >> 1;
      br  <= br >> 1;
      c   <= c_next;
      rr  <= rr_next;
      cnt <= cnt + 1'b1;
      if (last_bit) begin
        sum_q  <= rr_next;
        cout_q <= c_next;
        ovf_q  <= cmsb ^ c_next;
      end
    end
  end

  // Status flags are pure decodes of the state register.
  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
    bus.sum  = sum_q;
    bus.cout = cout_q;
    bus.ovf  = ovf_q;
  end

endmodule
